// File: rtl/key_conditioner.sv
// key_conditioner
//   Cleans up the raw TM1638 key bus before the game FSM and paddle logic
//   see it. Each key is synchronised, debounced on the game tick strobe and
//   turned into a stable level plus press, release and auto-repeat pulses.
//   A configurable multi-key chord is reported as a clean level and a single
//   press pulse.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   tick         in   one-clock strobe that advances every counter
//   key_raw      in   [n_keys] asynchronous raw key levels, 1 = pressed
//   key_level    out  [n_keys] debounced stable level
//   key_press    out  [n_keys] one-clock pulse on a debounced 0->1 transition
//   key_release  out  [n_keys] one-clock pulse on a debounced 1->0 transition
//   key_repeat   out  [n_keys] one-clock auto-repeat pulse while held
//   chord_level  out  high while every key in chord_mask is at level 1
//   chord_press  out  one-clock pulse on the rise of chord_level
//
// Per-key repeat FSM state is held in rpt_state[] (st_idle / st_delay /
// st_repeat) so external checkers can bind to it directly.

module key_conditioner #(
  parameter int                n_keys              = 8,
  parameter int                debounce_ticks      = 3,
  parameter int                repeat_delay_ticks  = 40,
  parameter int                repeat_period_ticks = 8,
  parameter logic [n_keys-1:0] chord_mask          = 8'b0100_0010
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic [n_keys-1:0] key_raw,
  output logic [n_keys-1:0] key_level,
  output logic [n_keys-1:0] key_press,
  output logic [n_keys-1:0] key_release,
  output logic [n_keys-1:0] key_repeat,
  output logic              chord_level,
  output logic              chord_press
);

  localparam int db_w    = $clog2(debounce_ticks + 1);
  localparam int rpt_max = (repeat_delay_ticks > repeat_period_ticks) ?
                           repeat_delay_ticks : repeat_period_ticks;
  localparam int rpt_w   = $clog2(rpt_max + 1);

  // Terminal compare values: the action happens on the tick that would
  // bring the count up to the parameter value.
  localparam logic [db_w-1:0]  db_last     = db_w'(debounce_ticks - 1);
  localparam logic [rpt_w-1:0] delay_last  = rpt_w'(repeat_delay_ticks - 1);
  localparam logic [rpt_w-1:0] period_last = rpt_w'(repeat_period_ticks - 1);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_delay  = 2'd1,
    st_repeat = 2'd2
  } rpt_state_t;

  // Synchroniser chain
  logic [n_keys-1:0] sync_1;
  logic [n_keys-1:0] sync_2;

  // Debounce
  logic [db_w-1:0]   db_cnt [n_keys];
  logic [n_keys-1:0] flip;
  logic [n_keys-1:0] rise;
  logic [n_keys-1:0] fall;

  // Repeat FSMs
  rpt_state_t        rpt_state   [n_keys];
  rpt_state_t        rpt_state_n [n_keys];
  logic [rpt_w-1:0]  rpt_cnt     [n_keys];
  logic [rpt_w-1:0]  rpt_cnt_n   [n_keys];
  logic [n_keys-1:0] repeat_n;

  logic chord_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
    end
  end

  // A level flip is only ever decided on a tick edge, so rise/fall (and the
  // press/release pulses derived from them) are naturally single-clock.
  always_comb begin
    flip = '0;
    rise = '0;
    fall = '0;
    for (int i = 0; i < n_keys; i++) begin
      flip[i] = tick && (sync_2[i] != key_level[i]) && (db_cnt[i] == db_last);
      rise[i] = flip[i] && !key_level[i];
      fall[i] = flip[i] &&  key_level[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < n_keys; i++) db_cnt[i] <= '0;
    end else begin
      key_press   <= rise;
      key_release <= fall;
      for (int i = 0; i < n_keys; i++) begin
        if (tick) begin
          if (sync_2[i] == key_level[i]) begin
            db_cnt[i] <= '0;
          end else if (flip[i]) begin
            db_cnt[i]    <= '0;
            key_level[i] <= ~key_level[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_repeat <= '0;
      for (int i = 0; i < n_keys; i++) begin
        rpt_state[i] <= st_idle;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      key_repeat <= repeat_n;
      for (int i = 0; i < n_keys; i++) begin
        rpt_state[i] <= rpt_state_n[i];
        rpt_cnt[i]   <= rpt_cnt_n[i];
      end
    end
  end

  always_comb begin
    repeat_n = '0;
    for (int i = 0; i < n_keys; i++) begin
      rpt_state_n[i] = rpt_state[i];
      rpt_cnt_n[i]   = rpt_cnt[i];
      case (rpt_state[i])
        st_idle: begin
          if (rise[i]) begin
            rpt_state_n[i] = st_delay;
            rpt_cnt_n[i]   = '0;
          end
        end
        st_delay: begin
          if (tick) begin
            if (rpt_cnt[i] == delay_last) begin
              repeat_n[i]    = 1'b1;
              rpt_cnt_n[i]   = '0;
              rpt_state_n[i] = st_repeat;
            end else begin
              rpt_cnt_n[i] = rpt_cnt[i] + 1'b1;
            end
          end
        end
        st_repeat: begin
          if (tick) begin
            if (rpt_cnt[i] == period_last) begin
              repeat_n[i]  = 1'b1;
              rpt_cnt_n[i] = '0;
            end else begin
              rpt_cnt_n[i] = rpt_cnt[i] + 1'b1;
            end
          end
        end
        default: begin
          rpt_state_n[i] = st_idle;
          rpt_cnt_n[i]   = '0;
        end
      endcase
      // A debounced fall overrides anything else, including a repeat that
      // would have landed on the same tick.
      if (fall[i]) begin
        rpt_state_n[i] = st_idle;
        rpt_cnt_n[i]   = '0;
        repeat_n[i]    = 1'b0;
      end
    end
  end

  // Built from the registered key_level, so the chord lags it by one clock.
  // An empty mask would otherwise reduce to a constant 1.
  assign chord_next = (chord_mask != '0) && (&(key_level | ~chord_mask));

  always_ff @(posedge clock) begin
    if (reset) begin
      chord_level <= 1'b0;
      chord_press <= 1'b0;
    end else begin
      chord_level <= chord_next;
      chord_press <= chord_next && !chord_level;
    end
  end

endmodule
